dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port of the single-cycle CPU between two requesters.
- Requester 0 is the CPU load/store path; requester 1 is a debug/loader path, used to preload or dump memory words without touching the CPU.
- Round-robin arbitration with a req/gnt handshake and a parameterised fixed read latency.
- One outstanding access at a time.

Parameters:
- ADDR_W, 32, address width of requesters and memory port.
- DATA_W, 32, data width.
- MEM_LAT, 0, read latency in cycles from the memory-enable cycle to valid mem_rdata_i; legal range 0..7.

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  reset, synchronous, active-high
- r0_req_i  input  1  requester 0 access request
- r0_we_i  input  1  1 = write, 0 = read
- r0_addr_i  input  ADDR_W  byte address
- r0_wdata_i  input  DATA_W  write data
- r0_gnt_o  output  1  one-cycle grant pulse
- r0_rvalid_o  output  1  one-cycle read-data-valid pulse
- r0_rdata_o  output  DATA_W  read data, meaningful only while r0_rvalid_o=1
- r1_req_i, r1_we_i, r1_addr_i, r1_wdata_i, r1_gnt_o, r1_rvalid_o, r1_rdata_o  same as requester 0
- mem_en_o  output  1  memory access strobe
- mem_we_o  output  1  memory write enable, qualified by mem_en_o
- mem_addr_o  output  ADDR_W  memory address
- mem_wdata_o  output  DATA_W  memory write data
- mem_rdata_i  input  DATA_W  memory read data
- busy_o  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - state=IDLE, last_grant=1 (so r0 wins the first contention), wait counter=0.
  - All gnt, rvalid, mem_en_o, mem_we_o and busy_o at 0; mem_addr_o=0; mem_wdata_o=0.
- States: IDLE, GNT, WAIT.
- IDLE:
  - Samples r0_req_i/r1_req_i.
  - If exactly one is high, that requester wins.
  - If both are high, the requester not equal to last_grant wins.
  - On a win, at the clock edge: register winner's we/addr/wdata into mem_*_o, update last_grant, go to GNT.
  - No request: stay in IDLE.
- GNT (exactly one cycle):
  - mem_en_o=1 and winner's gnt_o=1; mem_we_o = winner's we.
  - Write, or read with MEM_LAT=0: access completes here, next state is IDLE.
  - Read with MEM_LAT>0: load counter with MEM_LAT-1, go to WAIT.
- WAIT:
  - mem_en_o=0; mem_addr_o, mem_wdata_o and mem_we_o are held.
  - Counter decrements each cycle; when counter=0, return to IDLE.
- Read return:
  - Winner's rvalid_o pulses exactly MEM_LAT cycles after the GNT cycle (same cycle as GNT when MEM_LAT=0).
  - The read data port is mem_rdata_i driven combinationally.
  - The loser's rvalid_o stays 0.
- rdata_o outside rvalid: r0_rdata_o and r1_rdata_o both mirror mem_rdata_i; ignore them when rvalid is 0.
- Writes never produce rvalid.
- Requester handshake rules:
  - Hold req, we, addr and wdata stable from request until gnt is seen.
  - Deassert req in the cycle after gnt, unless issuing a new request.
  - req high in IDLE is always treated as a new request.
- Throughput: one access per 2 cycles for writes and MEM_LAT=0 reads; 2+MEM_LAT cycles for reads with MEM_LAT>0. Back-to-back grants are never issued without an IDLE cycle between them.
- Request during GNT/WAIT: not sampled; it is arbitered on the next IDLE cycle.
- Reset mid-GNT/WAIT: everything returns to reset values next cycle; the pending rvalid is dropped; last_grant returns to 1.
- Address rules: addresses and data pass unmodified. Word indexing and alignment are the memory's responsibility.
- Illegal MEM_LAT: a MEM_LAT outside 0..7 is rejected at elaboration by assertion.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, GNT, WAIT}.
  - LAT_CNT_W=3.
  - Requester index constants REQ_CPU=0, REQ_DBG=1.
- Sub-module rr_pick2 (combinational):
  - Inputs: req[1:0], last_grant.
  - Outputs: valid, winner index.
  - Arbiter FSM, counter and output registers stay in dmem_arbiter.

Test Plan:
- Reset: rst_i=1 for 2 cycles with both reqs high -> all outputs 0, busy_o=0. With rst_i=0 at cycle 0: IDLE samples at cycle 0 and r0 wins (first contention).
- Single write, MEM_LAT=2: r0 req we=1 addr=0x10 wdata=0x55 at cycle 0 -> cycle 1: r0_gnt_o=1, mem_en_o=1, mem_we_o=1, mem_addr_o=0x10, mem_wdata_o=0x55; no rvalid ever; busy_o=0 at cycle 2.
- Single read, MEM_LAT=2: r1 read addr=0x8 at cycle 0, memory model returns 0x1234 -> r1_gnt_o at cycle 1, r1_rvalid_o=1 with r1_rdata_o=0x1234 at cycle 3, r0_rvalid_o=0 throughout, IDLE at cycle 4.
- Contention: after reset, both requesters issue continuous writes (new request each cycle after gnt) -> grants alternate r0,r1,r0,r1 on cycles 1,3,5,7.
- Reset mid-WAIT, MEM_LAT=3: r0 read granted at cycle 1, rst_i=1 at cycle 2 -> no r0_rvalid_o pulse, busy_o=0 and mem_en_o=0 from cycle 3.
- MEM_LAT=0 read: r0 read addr=0x4, memory returns 0x7 combinationally -> r0_gnt_o, mem_en_o and r0_rvalid_o all high in the same cycle with rdata=0x7.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  localparam int LAT_CNT_W = 3;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, on contention the one
// that did not win last time wins.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       winner_o
);

  always_comb begin
    valid_o  = |req_i;
    winner_o = REQ_CPU;
    if (&req_i) begin
      winner_o = ~last_grant_i;
    end else if (req_i[REQ_DBG]) begin
      winner_o = REQ_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU (r0) and a debug/loader path
// (r1); round-robin, one outstanding access, fixed read latency MEM_LAT.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              r0_req_i,
  input  logic              r0_we_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_wdata_i,
  output logic              r0_gnt_o,
  output logic              r0_rvalid_o,
  output logic [DATA_W-1:0] r0_rdata_o,
  input  logic              r1_req_i,
  input  logic              r1_we_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_wdata_i,
  output logic              r1_gnt_o,
  output logic              r1_rvalid_o,
  output logic [DATA_W-1:0] r1_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  if (MEM_LAT < 0 || MEM_LAT > 7) begin : g_bad_lat
    $fatal(1, "dmem_arbiter: MEM_LAT must be within 0..7");
  end

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

  // Handshake: a requester holds req/we/addr/wdata stable until it sees its
  // one-cycle gnt; req is only sampled in IDLE, so a req seen there is always
  // a new access. Read data is valid only in the cycle rvalid pulses.
  arb_state_e            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  winner_q, winner_d;
  logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  logic pick_valid;
  logic pick_winner;
  logic rd_done;

  rr_pick2 u_pick (
    .req_i        ({r1_req_i, r0_req_i}),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .winner_o     (pick_winner)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          winner_d     = pick_winner;
          last_grant_d = pick_winner;
          we_d         = (pick_winner == REQ_DBG) ? r1_we_i    : r0_we_i;
          addr_d       = (pick_winner == REQ_DBG) ? r1_addr_i  : r0_addr_i;
          wdata_d      = (pick_winner == REQ_DBG) ? r1_wdata_i : r0_wdata_i;
          state_d      = GNT;
        end
      end
      GNT: begin
        if (!we_q && MEM_LAT != 0) begin
          cnt_d   = LAT_LOAD;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_DBG;
      winner_q     <= REQ_CPU;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // With zero latency the data returns in the GNT cycle itself.
  always_comb begin
    if (MEM_LAT == 0) begin
      rd_done = (state_q == GNT) && !we_q;
    end else begin
      rd_done = (state_q == WAIT) && (cnt_q == '0);
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign mem_en_o    = (state_q == GNT);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign r0_gnt_o    = mem_en_o && (winner_q == REQ_CPU);
  assign r1_gnt_o    = mem_en_o && (winner_q == REQ_DBG);
  assign r0_rvalid_o = rd_done && (winner_q == REQ_CPU);
  assign r1_rvalid_o = rd_done && (winner_q == REQ_DBG);
  assign r0_rdata_o  = mem_rdata_i;
  assign r1_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (MEM_LAT 0, 2, 3), directed vector
// table followed by randomized traffic against a transaction-schedule model.
module tb_dmem_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int NL      = 3;
  localparam int RND_CYC = 400;

  typedef struct packed {
    logic          g0, g1, v0, v1, en, we, busy;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } out_t;

  typedef struct {
    int            lane;
    logic          rst;
    logic          q0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          q1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    out_t          e;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst      [NL];
  logic          req      [NL][2];
  logic          wr       [NL][2];
  logic [AW-1:0] addr     [NL][2];
  logic [DW-1:0] wdat     [NL][2];
  logic          gnt      [NL][2];
  logic          rvld     [NL][2];
  logic [DW-1:0] rdat     [NL][2];
  logic          mem_en   [NL];
  logic          mem_we   [NL];
  logic [AW-1:0] mem_addr [NL];
  logic [DW-1:0] mem_wdat [NL];
  logic [DW-1:0] mem_rdat [NL];
  logic          busy     [NL];

  int checks   = 0;
  int failures = 0;

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    if (a == 32'h8) return 32'h1234;
    if (a == 32'h4) return 32'h7;
    return a ^ 32'hDEAD_BEEF;
  endfunction

  function automatic int lat_of(input int l);
    return (l == 0) ? 0 : (l == 1) ? 2 : 3;
  endfunction

  for (genvar l = 0; l < NL; l++) begin : g_lane
    localparam int LAT = (l == 0) ? 0 : (l == 1) ? 2 : 3;
    assign mem_rdat[l] = rd_fn(mem_addr[l]);
    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst[l]),
      .r0_req_i    (req[l][0]),
      .r0_we_i     (wr[l][0]),
      .r0_addr_i   (addr[l][0]),
      .r0_wdata_i  (wdat[l][0]),
      .r0_gnt_o    (gnt[l][0]),
      .r0_rvalid_o (rvld[l][0]),
      .r0_rdata_o  (rdat[l][0]),
      .r1_req_i    (req[l][1]),
      .r1_we_i     (wr[l][1]),
      .r1_addr_i   (addr[l][1]),
      .r1_wdata_i  (wdat[l][1]),
      .r1_gnt_o    (gnt[l][1]),
      .r1_rvalid_o (rvld[l][1]),
      .r1_rdata_o  (rdat[l][1]),
      .mem_en_o    (mem_en[l]),
      .mem_we_o    (mem_we[l]),
      .mem_addr_o  (mem_addr[l]),
      .mem_wdata_o (mem_wdat[l]),
      .mem_rdata_i (mem_rdat[l]),
      .busy_o      (busy[l])
    );
  end

  // scoreboard helpers
  task automatic chk_bit(input string name, input int l, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lane%0d: got %b expected %b", name, l, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input int l, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lane%0d: got 0x%08h expected 0x%08h", name, l, act, exp);
    end
  endtask

  task automatic check_out(input int l, input out_t e, input string tag);
    chk_bit({tag, " r0_gnt"}, l, gnt[l][0], e.g0);
    chk_bit({tag, " r1_gnt"}, l, gnt[l][1], e.g1);
    chk_bit({tag, " r0_rvalid"}, l, rvld[l][0], e.v0);
    chk_bit({tag, " r1_rvalid"}, l, rvld[l][1], e.v1);
    chk_bit({tag, " mem_en"}, l, mem_en[l], e.en);
    chk_bit({tag, " mem_we"}, l, mem_we[l], e.we);
    chk_bit({tag, " busy"}, l, busy[l], e.busy);
    chk_word({tag, " mem_addr"}, l, mem_addr[l], e.addr);
    chk_word({tag, " mem_wdata"}, l, mem_wdat[l], e.wdata);
    chk_word({tag, " r0_rdata"}, l, rdat[l][0], rd_fn(e.addr));
    chk_word({tag, " r1_rdata"}, l, rdat[l][1], rd_fn(e.addr));
  endtask

  // driver helpers
  task automatic drive_quiet();
    for (int l = 0; l < NL; l++) begin
      rst[l] = 1'b1;
      for (int k = 0; k < 2; k++) begin
        req[l][k] = 1'b0; wr[l][k] = 1'b0; addr[l][k] = '0; wdat[l][k] = '0;
      end
    end
  endtask

  function automatic vec_t mkv(input int lane, input logic rs,
                               input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic q1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                               input logic [6:0] f, input logic [31:0] ea, input logic [31:0] ed);
    vec_t v;
    v.lane = lane; v.rst = rs;
    v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.e = out_t'({f, ea, ed});
    return v;
  endfunction

  // reference model: per-lane schedule of grant/return/busy cycles
  int            nxt_idle [NL];
  int            gnt_c    [NL];
  int            rv_c     [NL];
  int            busy_hi  [NL];
  int            pend_c   [NL];
  logic          gnt_w    [NL];
  logic          last     [NL];
  logic          cur_we   [NL];
  logic [AW-1:0] cur_addr [NL];
  logic [DW-1:0] cur_wd   [NL];
  logic          pend_we  [NL];
  logic [AW-1:0] pend_addr[NL];
  logic [DW-1:0] pend_wd  [NL];
  logic          h_req    [NL][2];
  logic          h_we     [NL][2];
  logic [AW-1:0] h_addr   [NL][2];
  logic [DW-1:0] h_wd     [NL][2];

  task automatic model_reset(input int l, input int c);
    pend_c[l] = c + 1; pend_we[l] = 1'b0; pend_addr[l] = '0; pend_wd[l] = '0;
    nxt_idle[l] = c + 1; gnt_c[l] = -1; rv_c[l] = -1; busy_hi[l] = -1;
    last[l] = 1'b1;
  endtask

  vec_t vq[$];

  initial begin
    vec_t v;
    out_t e;
    logic w;
    int   lat;

    // lane 1 (MEM_LAT=2): reset, first contention, write then read
    vq.push_back(mkv(1,1, 1,1,32'h10,32'h55, 1,0,32'h8,0, 7'b0000000, 32'h0,  32'h0));
    vq.push_back(mkv(1,1, 1,1,32'h10,32'h55, 1,0,32'h8,0, 7'b0000000, 32'h0,  32'h0));
    vq.push_back(mkv(1,0, 1,1,32'h10,32'h55, 1,0,32'h8,0, 7'b0000000, 32'h0,  32'h0));
    vq.push_back(mkv(1,0, 0,0,0,0,           1,0,32'h8,0, 7'b1000111, 32'h10, 32'h55));
    vq.push_back(mkv(1,0, 0,0,0,0,           1,0,32'h8,0, 7'b0000010, 32'h10, 32'h55));
    vq.push_back(mkv(1,0, 0,0,0,0,           1,0,32'h8,0, 7'b0100101, 32'h8,  32'h0));
    vq.push_back(mkv(1,0, 0,0,0,0,           0,0,0,0,     7'b0000001, 32'h8,  32'h0));
    vq.push_back(mkv(1,0, 0,0,0,0,           0,0,0,0,     7'b0001001, 32'h8,  32'h0));
    vq.push_back(mkv(1,0, 0,0,0,0,           0,0,0,0,     7'b0000000, 32'h8,  32'h0));
    // lane 1: reset then continuous contending writes alternate r0,r1,...
    vq.push_back(mkv(1,1, 0,0,0,0, 0,0,0,0, 7'b0000000, 32'h8, 32'h0));
    vq.push_back(mkv(1,0, 1,1,32'h20,32'hA0, 1,1,32'h24,32'hB1, 7'b0000000, 32'h0,  32'h0));
    vq.push_back(mkv(1,0, 1,1,32'h20,32'hA0, 1,1,32'h24,32'hB1, 7'b1000111, 32'h20, 32'hA0));
    vq.push_back(mkv(1,0, 1,1,32'h20,32'hA0, 1,1,32'h24,32'hB1, 7'b0000010, 32'h20, 32'hA0));
    vq.push_back(mkv(1,0, 1,1,32'h20,32'hA0, 1,1,32'h24,32'hB1, 7'b0100111, 32'h24, 32'hB1));
    vq.push_back(mkv(1,0, 1,1,32'h20,32'hA0, 1,1,32'h24,32'hB1, 7'b0000010, 32'h24, 32'hB1));
    vq.push_back(mkv(1,0, 1,1,32'h20,32'hA0, 1,1,32'h24,32'hB1, 7'b1000111, 32'h20, 32'hA0));
    vq.push_back(mkv(1,0, 1,1,32'h20,32'hA0, 1,1,32'h24,32'hB1, 7'b0000010, 32'h20, 32'hA0));
    vq.push_back(mkv(1,0, 1,1,32'h20,32'hA0, 1,1,32'h24,32'hB1, 7'b0100111, 32'h24, 32'hB1));
    // lane 2 (MEM_LAT=3): reset in WAIT drops the pending rvalid
    vq.push_back(mkv(2,1, 0,0,0,0,       0,0,0,0, 7'b0000000, 32'h0,  32'h0));
    vq.push_back(mkv(2,0, 1,0,32'h30,0,  0,0,0,0, 7'b0000000, 32'h0,  32'h0));
    vq.push_back(mkv(2,0, 1,0,32'h30,0,  0,0,0,0, 7'b1000101, 32'h30, 32'h0));
    vq.push_back(mkv(2,1, 0,0,0,0,       0,0,0,0, 7'b0000001, 32'h30, 32'h0));
    vq.push_back(mkv(2,0, 0,0,0,0,       0,0,0,0, 7'b0000000, 32'h0,  32'h0));
    vq.push_back(mkv(2,0, 0,0,0,0,       0,0,0,0, 7'b0000000, 32'h0,  32'h0));
    vq.push_back(mkv(2,0, 0,0,0,0,       0,0,0,0, 7'b0000000, 32'h0,  32'h0));
    vq.push_back(mkv(2,0, 0,0,0,0,       0,0,0,0, 7'b0000000, 32'h0,  32'h0));
    // lane 0 (MEM_LAT=0): gnt, mem_en and rvalid in the same cycle
    vq.push_back(mkv(0,1, 0,0,0,0,       0,0,0,0, 7'b0000000, 32'h0, 32'h0));
    vq.push_back(mkv(0,0, 1,0,32'h4,0,   0,0,0,0, 7'b0000000, 32'h0, 32'h0));
    vq.push_back(mkv(0,0, 1,0,32'h4,0,   0,0,0,0, 7'b1010101, 32'h4, 32'h0));
    vq.push_back(mkv(0,0, 0,0,0,0,       0,0,0,0, 7'b0000000, 32'h4, 32'h0));

    drive_quiet();
    repeat (3) @(posedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      drive_quiet();
      v = vq[i];
      rst[v.lane] = v.rst;
      req[v.lane][0] = v.q0; wr[v.lane][0] = v.w0; addr[v.lane][0] = v.a0; wdat[v.lane][0] = v.d0;
      req[v.lane][1] = v.q1; wr[v.lane][1] = v.w1; addr[v.lane][1] = v.a1; wdat[v.lane][1] = v.d1;
      @(negedge clk);
      check_out(v.lane, v.e, $sformatf("vec%0d", i));
    end

    // randomized traffic on all lanes against the schedule model
    for (int l = 0; l < NL; l++) begin
      model_reset(l, -5);
      pend_c[l] = -1;
      cur_we[l] = 1'b0; cur_addr[l] = '0; cur_wd[l] = '0;
      for (int k = 0; k < 2; k++) begin
        h_req[l][k] = 1'b0; h_we[l][k] = 1'b0; h_addr[l][k] = '0; h_wd[l][k] = '0;
      end
    end

    for (int c = 0; c < RND_CYC; c++) begin
      @(posedge clk); #1;
      for (int l = 0; l < NL; l++) begin
        if (pend_c[l] == c) begin
          cur_we[l] = pend_we[l]; cur_addr[l] = pend_addr[l]; cur_wd[l] = pend_wd[l];
        end
        for (int k = 0; k < 2; k++) begin
          if (!h_req[l][k] && $urandom_range(0, 1) == 1) begin
            h_req[l][k]  = 1'b1;
            h_we[l][k]   = 1'($urandom_range(0, 1));
            h_addr[l][k] = 32'($urandom_range(0, 15)) << 2;
            h_wd[l][k]   = $urandom;
          end
          req[l][k] = h_req[l][k]; wr[l][k] = h_we[l][k];
          addr[l][k] = h_addr[l][k]; wdat[l][k] = h_wd[l][k];
        end
        rst[l] = (c < 2) || ($urandom_range(0, 39) == 0);
      end
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        if (c >= 1) begin
          e.g0    = (gnt_c[l] == c) && (gnt_w[l] == 1'b0);
          e.g1    = (gnt_c[l] == c) && (gnt_w[l] == 1'b1);
          e.v0    = (rv_c[l] == c) && (gnt_w[l] == 1'b0);
          e.v1    = (rv_c[l] == c) && (gnt_w[l] == 1'b1);
          e.en    = (gnt_c[l] == c);
          e.busy  = (gnt_c[l] >= 0) && (c >= gnt_c[l]) && (c <= busy_hi[l]);
          e.we    = cur_we[l];
          e.addr  = cur_addr[l];
          e.wdata = cur_wd[l];
          check_out(l, e, $sformatf("rnd%0d", c));
        end
        if (gnt_c[l] == c) h_req[l][gnt_w[l]] = 1'b0;
        if (rst[l]) begin
          model_reset(l, c);
        end else if (c >= nxt_idle[l] && (req[l][0] || req[l][1])) begin
          w = (req[l][0] && req[l][1]) ? ~last[l] : req[l][1];
          lat = lat_of(l);
          last[l]      = w;
          gnt_w[l]     = w;
          gnt_c[l]     = c + 1;
          pend_c[l]    = c + 1;
          pend_we[l]   = wr[l][w];
          pend_addr[l] = addr[l][w];
          pend_wd[l]   = wdat[l][w];
          busy_hi[l]   = c + 1 + (wr[l][w] ? 0 : lat);
          rv_c[l]      = wr[l][w] ? -1 : c + 1 + lat;
          nxt_idle[l]  = busy_hi[l] + 1;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
